// File: rtl/multi_comp_checker.sv
// Self-test sequencer for a 4-input comparator flip-flop block: drives all 16 input
// vectors, checks the registered {x,y} responses against a golden model, reports result.
module multi_comp_checker #(
   parameter int LAT  = 2,
   parameter int NVEC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   output logic       c_o,
   output logic       d_o,
   input  logic       x_i,
   input  logic       y_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic [3:0] first_err_vec,
   output logic       first_err_valid
);

   localparam int DCW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [3:0]       stim_q;
   logic [DCW-1:0]   drain_cnt;
   logic             vld_p [LAT];
   logic [1:0]       exp_p [LAT];
   logic [3:0]       vec_p [LAT];
   logic             accept;
   logic             mismatch;
   logic [4:0]       err_cnt_nxt;

   function automatic logic [1:0] golden(input logic [3:0] v);
      logic a, b, c, d;
      a = v[3];
      b = v[2];
      c = v[1];
      d = v[0];
      return {(~((a & b) | c)) | (c & d), c & d};
   endfunction

   assign accept = (state == IDLE) && start;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRIVE;
         DRIVE:   if (stim_q == 4'(NVEC - 1)) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == DCW'(LAT - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stim_q    <= 4'd0;
         drain_cnt <= '0;
      end else begin
         state <= state_nxt;
         // The 4-bit vector wraps 15 -> 0 on leaving DRIVE, which is exactly the idle drive level.
         if (accept)
            stim_q <= 4'd0;
         else if (state == DRIVE)
            stim_q <= stim_q + 4'd1;
         else
            stim_q <= 4'd0;
         if (state == DRAIN)
            drain_cnt <= drain_cnt + DCW'(1);
         else
            drain_cnt <= '0;
      end
   end

   assign {a_o, b_o, c_o, d_o} = stim_q;
   assign busy = (state == DRIVE) || (state == DRAIN);
   assign done = (state == DONE);

   // Expectation pipeline, stage 0 captures the vector being driven this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
      end else begin
         vld_p[0] <= (state == DRIVE);
         for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      exp_p[0] <= golden(stim_q);
      vec_p[0] <= stim_q;
      for (int i = 1; i < LAT; i++) begin
         exp_p[i] <= exp_p[i-1];
         vec_p[i] <= vec_p[i-1];
      end
   end

   // Compare stage: pipeline tail lines up with the response to the same vector
   assign mismatch    = vld_p[LAT-1] && busy && ({x_i, y_i} != exp_p[LAT-1]);
   assign err_cnt_nxt = err_cnt + 5'(mismatch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt         <= 5'd0;
         pass            <= 1'b0;
         first_err_vec   <= 4'd0;
         first_err_valid <= 1'b0;
      end else if (accept) begin
         err_cnt         <= 5'd0;
         pass            <= 1'b0;
         first_err_vec   <= 4'd0;
         first_err_valid <= 1'b0;
      end else begin
         err_cnt <= err_cnt_nxt;
         if (mismatch && !first_err_valid) begin
            first_err_vec   <= vec_p[LAT-1];
            first_err_valid <= 1'b1;
         end
         // The final compare lands on the same edge as DRAIN -> DONE, so use the updated count.
         if (state == DRAIN && state_nxt == DONE)
            pass <= (err_cnt_nxt == 5'd0);
      end
   end

endmodule

// File: tb/tb_multi_comp_checker.sv
// Bench for multi_comp_checker: behavioural comparator models with injectable faults,
// and a reference result computed directly from the golden equations.
module tb_multi_comp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, start3;
   logic       a, b, c, d, x, y, busy, done, pass, fevld;
   logic [4:0] err;
   logic [3:0] fev;
   logic       a3, b3, c3, d3, x3, y3, busy3, done3, pass3, fevld3;
   logic [4:0] err3;
   logic [3:0] fev3;

   int tests = 0;
   int fails = 0;

   int         fault_mode;
   logic [1:0] flip [16];

   multi_comp_checker #(.LAT(2), .NVEC(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_o(a), .b_o(b), .c_o(c), .d_o(d), .x_i(x), .y_i(y),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err),
      .first_err_vec(fev), .first_err_valid(fevld));

   multi_comp_checker #(.LAT(3), .NVEC(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .x_i(x3), .y_i(y3),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
      .first_err_vec(fev3), .first_err_valid(fevld3));

   function automatic logic [1:0] golden(input logic [3:0] v);
      return {(~((v[3] & v[2]) | v[1])) | (v[1] & v[0]), v[1] & v[0]};
   endfunction

   function automatic logic [1:0] dut_resp(input logic [3:0] v);
      logic [1:0] g;
      g = golden(v);
      case (fault_mode)
         1: g[0] = 1'b0;
         2: g[1] = ~g[1];
         3: g = g ^ flip[v];
         default: ;
      endcase
      return g;
   endfunction

   // Comparator block models: 2-deep and 3-deep registered responses
   logic [1:0] rp2 [2];
   logic [1:0] rp3 [3];
   always @(posedge clk) begin
      rp2[0] <= dut_resp({a, b, c, d});
      rp2[1] <= rp2[0];
      rp3[0] <= golden({a3, b3, c3, d3});
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end
   assign {x, y}   = rp2[1];
   assign {x3, y3} = rp3[2];

   task automatic ref_result(output int e, output logic [3:0] fv, output logic fvalid);
      e = 0; fv = 4'd0; fvalid = 1'b0;
      for (int v = 0; v < 16; v++) begin
         if (dut_resp(4'(v)) != golden(4'(v))) begin
            e++;
            if (!fvalid) begin fvalid = 1'b1; fv = 4'(v); end
         end
      end
   endtask

   int         o_done_cyc, o_done_cnt, o_busy_cnt, o_stim_bad;
   logic       o_pass, o_fevld;
   logic [4:0] o_err;
   logic [3:0] o_fev;

   task automatic do_run(input bit sel, input bit extra_starts);
      o_done_cyc = -1; o_done_cnt = 0; o_busy_cnt = 0; o_stim_bad = 0;
      o_pass = 1'b0; o_fevld = 1'b0; o_err = 5'd0; o_fev = 4'd0;
      @(negedge clk);
      if (sel) start3 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start3 = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         logic bs, dn, kick;
         logic [3:0] st, want;
         bs = sel ? busy3 : busy;
         dn = sel ? done3 : done;
         st = sel ? {a3, b3, c3, d3} : {a, b, c, d};
         want = (cyc < 16) ? 4'(cyc) : 4'd0;
         if (bs) o_busy_cnt++;
         if (st !== want) o_stim_bad++;
         if (dn === 1'b1) begin
            o_done_cnt++;
            if (o_done_cyc < 0) o_done_cyc = cyc;
            o_pass = sel ? pass3 : pass;
            o_err  = sel ? err3 : err;
            o_fev  = sel ? fev3 : fev;
            o_fevld = sel ? fevld3 : fevld;
         end
         kick = extra_starts && (cyc == 5 || dn === 1'b1);
         if (sel) start3 = kick; else start = kick;
         @(negedge clk);
      end
      start = 1'b0; start3 = 1'b0;
   endtask

   task automatic check_result(input string nm, input int want_cyc);
      int e; logic [3:0] fv; logic fvalid;
      ref_result(e, fv, fvalid);
      tests++; if (o_done_cyc != want_cyc) begin fails++; $display("FAIL %s done_cycle got %0d want %0d", nm, o_done_cyc, want_cyc); end
      tests++; if (o_done_cnt != 1) begin fails++; $display("FAIL %s done_pulses got %0d want 1", nm, o_done_cnt); end
      tests++; if (o_busy_cnt != want_cyc) begin fails++; $display("FAIL %s busy_cycles got %0d want %0d", nm, o_busy_cnt, want_cyc); end
      tests++; if (o_stim_bad != 0) begin fails++; $display("FAIL %s stimulus_bad_cycles got %0d want 0", nm, o_stim_bad); end
      tests++; if (o_err !== 5'(e)) begin fails++; $display("FAIL %s err_cnt got %0d want %0d", nm, o_err, e); end
      tests++; if (o_pass !== (e == 0)) begin fails++; $display("FAIL %s pass got %b want %b", nm, o_pass, e == 0); end
      tests++; if (o_fevld !== fvalid) begin fails++; $display("FAIL %s first_err_valid got %b want %b", nm, o_fevld, fvalid); end
      if (fvalid) begin
         tests++; if (o_fev !== fv) begin fails++; $display("FAIL %s first_err_vec got %b want %b", nm, o_fev, fv); end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0; fault_mode = 0;
      #2;
      tests++; if ({a, b, c, d, busy, done, pass, fevld} !== 8'd0) begin fails++; $display("FAIL reset_ctrl got %b want 00000000", {a, b, c, d, busy, done, pass, fevld}); end
      tests++; if ({err, fev} !== 9'd0) begin fails++; $display("FAIL reset_counts got %h want 000", {err, fev}); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ideal();
      fault_mode = 0;
      do_run(0, 0);
      check_result("ideal", 18);
      repeat (5) @(negedge clk);
      tests++; if ({pass, err, fevld} !== {1'b1, 5'd0, 1'b0}) begin fails++; $display("FAIL ideal_hold got %b want 1000000", {pass, err, fevld}); end
   endtask

   task automatic test_y_stuck();
      fault_mode = 1;
      do_run(0, 0);
      check_result("y_stuck", 18);
      tests++; if ({o_err, o_fev} !== {5'd4, 4'b0011}) begin fails++; $display("FAIL y_stuck_const got %0d/%b want 4/0011", o_err, o_fev); end
      repeat (4) @(negedge clk);
      tests++; if ({err, fev, fevld, pass} !== {5'd4, 4'b0011, 1'b1, 1'b0}) begin fails++; $display("FAIL y_stuck_hold got %0d/%b want 4/0011", err, fev); end
   endtask

   task automatic test_x_inv();
      fault_mode = 2;
      do_run(0, 0);
      check_result("x_inv", 18);
      tests++; if ({o_err, o_fev, o_pass} !== {5'd16, 4'b0000, 1'b0}) begin fails++; $display("FAIL x_inv_const got %0d/%b/%b want 16/0000/0", o_err, o_fev, o_pass); end
   endtask

   task automatic test_random_faults();
      fault_mode = 3;
      for (int it = 0; it < 8; it++) begin
         for (int v = 0; v < 16; v++)
            flip[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_run(0, 0);
         check_result("random", 18);
      end
   endtask

   task automatic test_ignore_start();
      fault_mode = 1;
      do_run(0, 1);
      check_result("ignore_start", 18);
      repeat (3) @(negedge clk);
      tests++; if ({busy, err, fev} !== {1'b0, 5'd4, 4'b0011}) begin fails++; $display("FAIL ignore_start_after got %b/%0d/%b want 0/4/0011", busy, err, fev); end
   endtask

   task automatic test_mid_reset();
      int dn_seen;
      fault_mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      tests++; if ({a, b, c, d} !== 4'd8) begin fails++; $display("FAIL mid_reset_pre_vec got %b want 1000", {a, b, c, d}); end
      rst_n = 1'b0;
      #1;
      tests++; if ({a, b, c, d, busy, done, pass, fevld, err, fev} !== 17'd0) begin fails++; $display("FAIL mid_reset_outputs got %h want 0", {a, b, c, d, busy, done, pass, fevld, err, fev}); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      dn_seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done || busy) dn_seen++;
      end
      tests++; if (dn_seen != 0) begin fails++; $display("FAIL mid_reset_no_done got %0d active cycles want 0", dn_seen); end
      fault_mode = 0;
      do_run(0, 0);
      check_result("after_reset", 18);
   endtask

   task automatic test_lat3();
      fault_mode = 0;
      do_run(1, 0);
      check_result("lat3", 19);
   endtask

   task automatic test_back_to_back();
      fault_mode = 2;
      do_run(0, 0);
      check_result("b2b_first", 18);
      fault_mode = 0;
      do_run(0, 0);
      check_result("b2b_second", 18);
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_y_stuck();
      test_x_inv();
      test_random_faults();
      test_ignore_start();
      test_mid_reset();
      test_lat3();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_comp_checker.md
MULTI_COMP_CHECKER -- requirements
Module: multi_comp_checker

Interface
REQ-001 Parameter LAT, default 2: cycles from vector presented on a_o..d_o to matching response on x_i/y_i.
REQ-002 Parameter NVEC, default 16: vectors per run; fixed at 16, exhaustive over 4 input bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  run request, sampled in IDLE only.
REQ-007 a_o, b_o, c_o, d_o  output  1 each  stimulus to the multi-input comparator flip-flop block, registered.
REQ-008 x_i, y_i  input  1 each  registered response from that block.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  run result, valid from done until next accepted start.
REQ-012 err_cnt  output  5  mismatch count of the last run, 0..16.
REQ-013 first_err_vec  output  4  {a,b,c,d} of first mismatching vector; first_err_valid  output  1  qualifies it.

Function
REQ-014 Golden model SHALL be x = ~((a&b)|c) | (c&d), y = c&d.
REQ-015 FSM states SHALL be IDLE, DRIVE, DRAIN, DONE.
REQ-016 IDLE: a_o..d_o = 0, busy = 0; start=1 at an edge -> DRIVE, clears err_cnt, pass, first_err_valid, first_err_vec.
REQ-017 DRIVE: for cycle k = 0..15 after start accepted, {a_o,b_o,c_o,d_o} SHALL equal k (a_o MSB); after k = 15 -> DRAIN.
REQ-018 DRAIN: a_o..d_o = 0 for LAT cycles, then -> DONE.
REQ-019 DONE: done = 1 for exactly one cycle, pass = (err_cnt == 0) registered, then -> IDLE.
REQ-020 busy SHALL be 1 in DRIVE and DRAIN, 0 in IDLE and DONE.
REQ-021 Expected {x,y} for vector k SHALL travel through an LAT-deep pipeline with a valid bit per stage.
REQ-022 Response for vector k SHALL be compared with x_i/y_i sampled in cycle k+LAT; mismatch if either bit differs.
REQ-023 Each mismatch SHALL increment err_cnt by 1; no wrap is possible, max 16.
REQ-024 On the first mismatch of a run, first_err_vec <= vector k, first_err_valid <= 1; later mismatches SHALL NOT change them.
REQ-025 Comparisons SHALL occur only where the pipeline valid bit is set; no compare in IDLE or DONE.
REQ-026 start while busy or in DONE SHALL be ignored, with no restart and no effect on counters.
REQ-027 done SHALL occur in cycle 16+LAT, counted from the first DRIVE cycle as 0.
REQ-028 err_cnt, pass, first_err_* SHALL hold after DONE until the next accepted start.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, a_o..d_o = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, first_err_vec = 0, first_err_valid = 0, all pipeline valid bits = 0.
REQ-030 Reset mid-run SHALL abandon the run with no done pulse; the next start after rst_n rises SHALL run a complete fresh sequence.
REQ-031 Reset deassertion needs no sync beyond the flops; first start is accepted on the first edge with rst_n = 1.

Verification
REQ-032 Ideal DUT model (LAT = 2): pulse start -> busy for 18 cycles, done in cycle 18, pass = 1, err_cnt = 0, first_err_valid = 0.
REQ-033 DUT with y stuck at 0 -> err_cnt = 4 (vectors 0011, 0111, 1011, 1111), pass = 0, first_err_vec = 4'b0011.
REQ-034 DUT with x inverted -> err_cnt = 16, first_err_vec = 4'b0000, pass = 0.
REQ-035 start re-asserted in DRIVE cycle 5 and in DONE -> ignored; single done in cycle 18, counts unchanged.
REQ-036 rst_n low in DRIVE cycle 8 -> all outputs 0 immediately, no done; fresh start then gives the REQ-032 result.
REQ-037 LAT = 3 with a 3-cycle DUT model -> pass = 1, done in cycle 19.
